lane_retimer: RTL and testbench
===============================

LANE_RETIMER -- requirements
Module: lane_retimer

Interface
REQ-001 The module SHALL have parameter LANES, default 8, lane count (1..32).
REQ-002 The module SHALL have parameter LAT, default 2, input-to-output pipeline depth in cycles (1..4).
REQ-003 The module SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port ana_byp, input, 1: 1 = digital path drives lanes, 0 = analog bypass owns lanes.
REQ-006 The module SHALL have port lane_inputs, input, LANES, raw lane data, synchronous to clk.
REQ-007 The module SHALL have port lane_outputs, output, LANES, retimed lane data.
REQ-008 The module SHALL have port lane_valid, output, 1, high while lane_outputs track lane_inputs.
REQ-009 The module SHALL have port chg_cnt, output, 16, saturating count of cycles in which lane_inputs changed while tracking.
REQ-010 The module SHALL have port chg_clr, input, 1, synchronous clear of chg_cnt.

Function
REQ-011 The FSM SHALL have states HOLD, FLUSH and TRACK.
REQ-012 HOLD SHALL move to FLUSH on the first cycle ana_byp is sampled 1.
REQ-013 FLUSH SHALL last exactly LAT cycles, loading every pipe stage with the current lane_inputs, then move to TRACK.
REQ-014 In TRACK, lane_outputs SHALL equal lane_inputs sampled LAT cycles earlier.
REQ-015 Consequently, every change on lane_inputs in TRACK SHALL produce a change on lane_outputs exactly LAT cycles later.
REQ-016 In FLUSH or TRACK, ana_byp sampled 0 SHALL move the FSM to HOLD next cycle.
REQ-017 In HOLD, lane_outputs SHALL freeze at their last value.
REQ-018 lane_valid SHALL be 1 only in TRACK and SHALL be registered.
REQ-019 chg_cnt SHALL increment when in TRACK and lane_inputs differs from its previous-cycle value.
REQ-020 chg_cnt SHALL saturate at 16'hFFFF.
REQ-021 chg_clr SHALL take priority over increment; both in the same cycle SHALL yield 0.
REQ-022 ana_byp toggling 1->0->1 within FLUSH SHALL restart FLUSH with a full LAT count.
REQ-023 A change of lane_inputs during FLUSH SHALL NOT count and SHALL NOT shorten FLUSH.

Reset
REQ-024 rst_n low SHALL asynchronously force state HOLD, all pipe stages to 0, lane_outputs to 0, lane_valid to 0 and chg_cnt to 0.
REQ-025 Reset asserted mid-TRACK SHALL take effect immediately.
REQ-026 After reset release, the first rising edge with ana_byp=1 SHALL enter FLUSH.

Configuration
REQ-027 With macro LANE_RETIMER_PARITY_EN defined, the module SHALL add output lane_par, 1 bit.
REQ-028 lane_par SHALL be a register equal to the XOR of the lane_outputs value in the same cycle.
REQ-029 lane_par SHALL reset to 0 and SHALL freeze in HOLD.
REQ-030 Without LANE_RETIMER_PARITY_EN, the lane_par port and its logic SHALL be absent.
REQ-031 All other behaviour SHALL be identical with and without LANE_RETIMER_PARITY_EN.

Verification
REQ-032 Scenario: LAT=2, reset, ana_byp=1 at cycle 0, lane_inputs=8'hA5 -> lane_valid=1 from cycle 3 and lane_outputs=8'hA5.
REQ-033 Scenario: TRACK, lane_inputs 8'h00->8'hFF at cycle N -> lane_outputs=8'hFF at N+2 and chg_cnt +1.
REQ-034 Scenario: TRACK, ana_byp=0 while lane_inputs keep toggling -> lane_valid=0 next cycle, lane_outputs frozen, chg_cnt unchanged.
REQ-035 Scenario: chg_cnt forced to 16'hFFFE, three input changes -> chg_cnt=16'hFFFF; chg_clr asserted with a change -> chg_cnt=0.
REQ-036 Scenario: rst_n low mid-TRACK between edges -> all outputs 0 immediately, without waiting for a clock edge.
REQ-037 Scenario: LANE_RETIMER_PARITY_EN defined, lane_outputs=8'h07 -> lane_par=1; lane_outputs=8'h03 -> lane_par=0.

Source files
------------

// File: rtl/lane_retimer.sv
// lane_retimer: LANES-wide retiming pipeline of depth LAT that takes over the lanes from an
// analog bypass via HOLD -> FLUSH -> TRACK. Define LANE_RETIMER_PARITY_EN to add output lane_par.

module lane_retimer #(
    parameter int LANES = 8,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ana_byp,
    input  logic [LANES-1:0] lane_inputs,
    input  logic             chg_clr,
    output logic [LANES-1:0] lane_outputs,
    output logic             lane_valid,
    output logic [15:0]      chg_cnt
`ifdef LANE_RETIMER_PARITY_EN
    ,
    output logic             lane_par
`endif
);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        FLUSH = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_LAST = 2'(LAT - 1);

    function automatic logic parity_f(input logic [LANES-1:0] data);
        parity_f = ^data;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [1:0]       flush_cnt_r;
    logic [1:0]       flush_cnt_next_s;
    logic [LANES-1:0] pipe_r      [LAT];
    logic [LANES-1:0] pipe_next_s [LAT];
    logic [LANES-1:0] prev_in_r;
    logic [15:0]      chg_cnt_r;
    logic [15:0]      chg_cnt_next_s;
    logic             lane_valid_r;
    logic             advance_s;
    logic             last_flush_s;
    logic             count_s;

    // The pipe only moves while the digital path owns the lanes; ana_byp=0 freezes it at once.
    always_comb begin
        advance_s    = ana_byp && (state_r != HOLD);
        last_flush_s = (state_r == FLUSH) && (flush_cnt_r == FLUSH_LAST);
        count_s      = (state_r == TRACK) && ana_byp && (lane_inputs != prev_in_r);
    end

    // Next-state logic for the HOLD/FLUSH/TRACK handover.
    always_comb begin
        state_next_s     = state_r;
        flush_cnt_next_s = flush_cnt_r;
        case (state_r)
            HOLD: begin
                if (ana_byp) begin
                    state_next_s     = FLUSH;
                    flush_cnt_next_s = 2'd0;
                end else begin
                    state_next_s = HOLD;
                end
            end
            FLUSH: begin
                if (!ana_byp) begin
                    state_next_s = HOLD;
                end else if (last_flush_s) begin
                    state_next_s = TRACK;
                end else begin
                    flush_cnt_next_s = flush_cnt_r + 2'd1;
                end
            end
            TRACK: begin
                if (!ana_byp) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = TRACK;
                end
            end
            default: begin
                state_next_s     = HOLD;
                flush_cnt_next_s = 2'd0;
            end
        endcase
    end

    // Pipe next values: FLUSH fills every stage with the live input; the final flush cycle
    // shifts instead so TRACK starts with a true LAT-deep history.
    always_comb begin
        for (int i = 0; i < LAT; i++) begin
            pipe_next_s[i] = pipe_r[i];
        end
        if (advance_s) begin
            pipe_next_s[0] = lane_inputs;
            for (int i = 1; i < LAT; i++) begin
                if ((state_r == FLUSH) && !last_flush_s) begin
                    pipe_next_s[i] = lane_inputs;
                end else begin
                    pipe_next_s[i] = pipe_r[i-1];
                end
            end
        end else begin
            pipe_next_s[0] = pipe_r[0];
        end
    end

    // Change counter: clear wins over increment, saturates at all-ones.
    always_comb begin
        chg_cnt_next_s = chg_cnt_r;
        if (chg_clr) begin
            chg_cnt_next_s = 16'd0;
        end else if (count_s && (chg_cnt_r != 16'hFFFF)) begin
            chg_cnt_next_s = chg_cnt_r + 16'd1;
        end else begin
            chg_cnt_next_s = chg_cnt_r;
        end
    end

    // FSM state and flush counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HOLD;
            flush_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_next_s;
            flush_cnt_r <= flush_cnt_next_s;
        end
    end

    // Data pipe, previous-input history, change counter and valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= {LANES{1'b0}};
            end
            prev_in_r    <= {LANES{1'b0}};
            chg_cnt_r    <= 16'd0;
            lane_valid_r <= 1'b0;
        end else begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= pipe_next_s[i];
            end
            prev_in_r    <= lane_inputs;
            chg_cnt_r    <= chg_cnt_next_s;
            lane_valid_r <= (state_next_s == TRACK);
        end
    end

    assign lane_outputs = pipe_r[LAT-1];
    assign lane_valid   = lane_valid_r;
    assign chg_cnt      = chg_cnt_r;

`ifdef LANE_RETIMER_PARITY_EN
    logic lane_par_r;

    // Parity follows the output stage on the same edge, so it freezes with it in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_par_r <= 1'b0;
        end else begin
            lane_par_r <= parity_f(pipe_next_s[LAT-1]);
        end
    end

    assign lane_par = lane_par_r;
`endif

endmodule

// File: tb/tb_lane_retimer.sv
// Directed self-checking bench for lane_retimer (LANES=8, LAT=2); parity checks are built
// only when LANE_RETIMER_PARITY_EN is defined.

module tb_lane_retimer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ana_byp;
    logic        chg_clr;
    logic [7:0]  lane_inputs;
    logic [7:0]  lane_outputs;
    logic        lane_valid;
    logic [15:0] chg_cnt;
`ifdef LANE_RETIMER_PARITY_EN
    logic        lane_par;
`endif

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    lane_retimer #(.LANES(8), .LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ana_byp      (ana_byp),
        .lane_inputs  (lane_inputs),
        .chg_clr      (chg_clr),
        .lane_outputs (lane_outputs),
        .lane_valid   (lane_valid),
        .chg_cnt      (chg_cnt)
`ifdef LANE_RETIMER_PARITY_EN
        ,
        .lane_par     (lane_par)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ana_byp = 1'b0; chg_clr = 1'b0; lane_inputs = 8'h00;
        tick(); tick();
        tests_run++;
        if (lane_outputs !== 8'h00 || lane_valid !== 1'b0 || chg_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset: out=%h valid=%b cnt=%h expected 00/0/0000", lane_outputs, lane_valid, chg_cnt);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (lane_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_after_reset: valid=%b expected 0", lane_valid);
        end
    endtask

    task automatic test_flush_entry();
        ana_byp = 1'b1; lane_inputs = 8'hA5;
        tick();
        tests_run++;
        if (lane_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_c1: valid=%b expected 0", lane_valid);
        end
        tick();
        tests_run++;
        if (lane_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_c2: valid=%b expected 0", lane_valid);
        end
        tick();
        tests_run++;
        if (lane_valid !== 1'b1 || lane_outputs !== 8'hA5 || chg_cnt !== 16'd0) begin
            fails++;
            $display("FAIL track_c3: valid=%b out=%h cnt=%h expected 1/a5/0000", lane_valid, lane_outputs, chg_cnt);
        end
    endtask

    task automatic test_track_latency();
        lane_inputs = 8'h00;
        tick();
        tests_run++;
        if (chg_cnt !== 16'd1) begin
            fails++;
            $display("FAIL cnt_a5_00: cnt=%h expected 0001", chg_cnt);
        end
        tick();
        tests_run++;
        if (lane_outputs !== 8'h00) begin
            fails++;
            $display("FAIL out_00: out=%h expected 00", lane_outputs);
        end
        tick();
        lane_inputs = 8'hFF;
        tick();
        tests_run++;
        if (lane_outputs !== 8'h00 || chg_cnt !== 16'd2) begin
            fails++;
            $display("FAIL ff_n1: out=%h cnt=%h expected 00/0002", lane_outputs, chg_cnt);
        end
        tick();
        tests_run++;
        if (lane_outputs !== 8'hFF) begin
            fails++;
            $display("FAIL ff_n2: out=%h expected ff", lane_outputs);
        end
        lane_inputs = 8'h3C;
        tick();
        lane_inputs = 8'h5A;
        tick();
        tests_run++;
        if (lane_outputs !== 8'h3C) begin
            fails++;
            $display("FAIL b2b_3c: out=%h expected 3c", lane_outputs);
        end
        tick();
        tests_run++;
        if (lane_outputs !== 8'h5A || chg_cnt !== 16'd4) begin
            fails++;
            $display("FAIL b2b_5a: out=%h cnt=%h expected 5a/0004", lane_outputs, chg_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] toggles [3];
        toggles[0] = 8'hA5; toggles[1] = 8'h0F; toggles[2] = 8'hF0;
        ana_byp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lane_inputs = toggles[i];
            tick();
            tests_run++;
            if (lane_valid !== 1'b0 || lane_outputs !== 8'h5A || chg_cnt !== 16'd4) begin
                fails++;
                $display("FAIL bypass_%0d: valid=%b out=%h cnt=%h expected 0/5a/0004", i, lane_valid, lane_outputs, chg_cnt);
            end
        end
    endtask

    task automatic test_flush_restart();
        ana_byp = 1'b1; lane_inputs = 8'h11;
        tick();
        ana_byp = 1'b0;
        tick();
        tests_run++;
        if (lane_valid !== 1'b0 || lane_outputs !== 8'h5A) begin
            fails++;
            $display("FAIL restart_drop: valid=%b out=%h expected 0/5a", lane_valid, lane_outputs);
        end
        ana_byp = 1'b1;
        tick();
        lane_inputs = 8'h22;
        tick();
        tests_run++;
        if (lane_valid !== 1'b0) begin
            fails++;
            $display("FAIL restart_full: valid=%b expected 0", lane_valid);
        end
        tick();
        tests_run++;
        if (lane_valid !== 1'b1 || lane_outputs !== 8'h22 || chg_cnt !== 16'd4) begin
            fails++;
            $display("FAIL restart_track: valid=%b out=%h cnt=%h expected 1/22/0004", lane_valid, lane_outputs, chg_cnt);
        end
    endtask

    task automatic test_saturation();
        chg_clr = 1'b1;
        tick();
        chg_clr = 1'b0;
        tests_run++;
        if (chg_cnt !== 16'd0) begin
            fails++;
            $display("FAIL clr: cnt=%h expected 0000", chg_cnt);
        end
        for (int i = 0; i < 65534; i++) begin
            lane_inputs = (i % 2 == 0) ? 8'hDD : 8'h22;
            tick();
        end
        tests_run++;
        if (chg_cnt !== 16'hFFFE) begin
            fails++;
            $display("FAIL cnt_fffe: cnt=%h expected fffe", chg_cnt);
        end
        lane_inputs = 8'hDD; tick();
        tests_run++;
        if (chg_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL cnt_ffff: cnt=%h expected ffff", chg_cnt);
        end
        lane_inputs = 8'h22; tick();
        lane_inputs = 8'hDD; tick();
        tests_run++;
        if (chg_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL cnt_sat: cnt=%h expected ffff", chg_cnt);
        end
        chg_clr = 1'b1; lane_inputs = 8'h22;
        tick();
        chg_clr = 1'b0;
        tests_run++;
        if (chg_cnt !== 16'd0) begin
            fails++;
            $display("FAIL clr_prio: cnt=%h expected 0000", chg_cnt);
        end
        lane_inputs = 8'h5A;
        tick();
        tests_run++;
        if (chg_cnt !== 16'd1) begin
            fails++;
            $display("FAIL cnt_after_clr: cnt=%h expected 0001", chg_cnt);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        lane_inputs = 8'hC3;
        #1;
        tests_run++;
        if (lane_outputs !== 8'h00 || lane_valid !== 1'b0 || chg_cnt !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: out=%h valid=%b cnt=%h expected 00/0/0000", lane_outputs, lane_valid, chg_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (lane_valid !== 1'b0) begin
            fails++;
            $display("FAIL rel_c1: valid=%b expected 0", lane_valid);
        end
        tick();
        tick();
        tests_run++;
        if (lane_valid !== 1'b1 || lane_outputs !== 8'hC3 || chg_cnt !== 16'd0) begin
            fails++;
            $display("FAIL rel_track: valid=%b out=%h cnt=%h expected 1/c3/0000", lane_valid, lane_outputs, chg_cnt);
        end
    endtask

`ifdef LANE_RETIMER_PARITY_EN
    task automatic test_parity();
        lane_inputs = 8'h07;
        tick(); tick();
        tests_run++;
        if (lane_outputs !== 8'h07 || lane_par !== 1'b1) begin
            fails++;
            $display("FAIL par_07: out=%h par=%b expected 07/1", lane_outputs, lane_par);
        end
        lane_inputs = 8'h03;
        tick(); tick();
        tests_run++;
        if (lane_outputs !== 8'h03 || lane_par !== 1'b0) begin
            fails++;
            $display("FAIL par_03: out=%h par=%b expected 03/0", lane_outputs, lane_par);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_flush_entry();
        test_track_latency();
        test_bypass();
        test_flush_restart();
        test_saturation();
        test_async_reset();
`ifdef LANE_RETIMER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
